// File: rtl/fp_cmp_arbiter.sv
// Round-robin arbiter that time-shares one fp_comparator_32bit among NUM_REQ
// requesters, sequencing its ready/data_valid/calc_done/read_done handshake.
module fp_cmp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ack,
    output logic [2:0]            rsp_result,
    output logic                  rsp_unordered,
    output logic                  busy,
    input  logic                  cmp_ready,
    output logic                  cmp_data_valid,
    input  logic                  cmp_calc_done,
    output logic                  cmp_read_done,
    output logic [31:0]           cmp_a,
    output logic [31:0]           cmp_b,
    input  logic [2:0]            cmp_result
);

    // Requester handshake: req_valid is a level held until the one-cycle
    // req_ready pulse; rsp_valid is held until the owner raises rsp_ack.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2:0]           rsp_result_q, rsp_result_d;
    logic                 rsp_unord_q, rsp_unord_d;
    logic                 busy_q, busy_d;
    logic                 data_valid_q, data_valid_d;
    logic                 read_done_q, read_done_d;
    logic [31:0]          cmp_a_q, cmp_a_d;
    logic [31:0]          cmp_b_q, cmp_b_d;

    logic [31:0]          a_arr [NUM_REQ];
    logic [31:0]          b_arr [NUM_REQ];
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[32*i +: 32];
        assign b_arr[i] = req_b[32*i +: 32];
    end

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        req_ready_d  = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_unord_d  = rsp_unord_q;
        data_valid_d = 1'b0;
        read_done_d  = 1'b0;
        cmp_a_d      = cmp_a_q;
        cmp_b_d      = cmp_b_q;

        case (state_q)
            S_IDLE: begin
                if (cmp_ready && grant_found) begin
                    owner_d                = grant_idx;
                    cmp_a_d                = a_arr[grant_idx];
                    cmp_b_d                = b_arr[grant_idx];
                    req_ready_d[grant_idx] = 1'b1;
                    data_valid_d           = 1'b1;
                    if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + IDX_W'(1);
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cmp_calc_done) begin
                    rsp_result_d         = cmp_result;
                    rsp_unord_d          = (cmp_result == 3'b000);
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    read_done_d          = 1'b1;
                    state_d              = S_READ;
                end
            end
            S_READ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ack[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= 3'b000;
            rsp_unord_q  <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            read_done_q  <= 1'b0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_unord_q  <= rsp_unord_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
            read_done_q  <= read_done_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = rsp_result_q;
    assign rsp_unordered  = rsp_unord_q;
    assign busy           = busy_q;
    assign cmp_data_valid = data_valid_q;
    assign cmp_read_done  = read_done_q;
    assign cmp_a          = cmp_a_q;
    assign cmp_b          = cmp_b_q;

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Directed bench for fp_cmp_arbiter with a behavioural fp_comparator_32bit
// model on the comparator side of the handshake.
module tb_fp_cmp_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a, req_b;
    logic [N-1:0]    req_ready, rsp_valid, rsp_ack;
    logic [2:0]      rsp_result;
    logic            rsp_unordered, busy;
    logic            cmp_ready, cmp_data_valid, cmp_calc_done, cmp_read_done;
    logic [31:0]     cmp_a, cmp_b;
    logic [2:0]      cmp_result;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [N-1:0] exp_q[$];

    fp_cmp_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_result(rsp_result), .rsp_unordered(rsp_unordered), .busy(busy),
        .cmp_ready(cmp_ready), .cmp_data_valid(cmp_data_valid),
        .cmp_calc_done(cmp_calc_done), .cmp_read_done(cmp_read_done),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_result(cmp_result)
    );

    always #5 clk = ~clk;

    // ---------------- comparator model ----------------
    function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 3'b000;
        if (a[30:0] == 0 && b[30:0] == 0)
            return 3'b010;
        ka = a[31] ? ~a : (a | 32'h8000_0000);
        kb = b[31] ? ~b : (b | 32'h8000_0000);
        if (ka > kb) return 3'b100;
        if (ka == kb) return 3'b010;
        return 3'b001;
    endfunction

    logic [2:0]  cst;   // 0 idle, 1 comparing, 2 done, 3 hold calc_done, 4 release
    logic [31:0] m_a, m_b;
    logic        ready_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cst <= 3'd0; m_a <= '0; m_b <= '0; cmp_result <= 3'b000;
        end else begin
            case (cst)
                3'd0: if (cmp_data_valid && cmp_ready) begin
                    m_a <= cmp_a; m_b <= cmp_b; cst <= 3'd1;
                end
                3'd1: begin cmp_result <= fcmp(m_a, m_b); cst <= 3'd2; end
                3'd2: cst <= 3'd3;
                3'd3: if (cmp_read_done) cst <= 3'd4;
                default: cst <= 3'd0;
            endcase
        end
    end

    assign cmp_ready     = (cst == 3'd0) && !ready_off;
    assign cmp_calc_done = (cst == 3'd3);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic        rd_prev = 1'b0;
    logic [31:0] lat_a = '0, lat_b = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 0) begin
                if (exp_q.size() > 0) check("grant", req_ready, exp_q.pop_front());
                else check("unexpected_grant", req_ready, 0);
            end
            if (cmp_data_valid) begin
                check("dv_while_not_ready", cmp_ready, 1);
                lat_a = cmp_a;
                lat_b = cmp_b;
            end else if (busy) begin
                check("cmp_a_stable", cmp_a, lat_a);
                check("cmp_b_stable", cmp_b, lat_b);
            end
            if (cmp_read_done) check("read_done_width", rd_prev, 0);
            rd_prev = cmp_read_done;
        end else begin
            rd_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]      = 1'b1;
    endtask

    task automatic wait_ready(input int id, output int n);
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 60) begin tick(); n++; end
        if (req_ready[id] !== 1'b1) check("timeout_req_ready", 0, 1);
    endtask

    task automatic wait_rsp(input int id, output int n);
        n = 0;
        while (rsp_valid[id] !== 1'b1 && n < 60) begin tick(); n++; end
        if (rsp_valid[id] !== 1'b1) check("timeout_rsp_valid", 0, 1);
    endtask

    task automatic finish_rsp(input int id, input logic [2:0] exp_res);
        int n;
        logic [N-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        check("rsp_owner_only", rsp_valid, oh);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_unordered", rsp_unordered, (exp_res == 3'b000));
        rsp_ack[id] = 1'b1;
        n = 0;
        while (rsp_valid[id] !== 1'b0 && n < 20) begin tick(); n++; end
        if (rsp_valid[id] !== 1'b0) check("timeout_rsp_clear", 0, 1);
        rsp_ack[id] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_unord"}, rsp_unordered, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dv"}, cmp_data_valid, 0);
        check({tag, "_rd"}, cmp_read_done, 0);
        check({tag, "_cmp_a"}, cmp_a, 0);
        check({tag, "_cmp_b"}, cmp_b, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ack = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rr_a   [N] = '{32'h3F80_0000, 32'h4000_0000, 32'h4049_0FDB, 32'hC000_0000};
    logic [31:0] rr_b   [N] = '{32'h4000_0000, 32'h3F80_0000, 32'h4049_0FDB, 32'h3F80_0000};
    logic [2:0]  rr_res [N] = '{3'b001, 3'b100, 3'b010, 3'b001};

    initial begin
        int n1, n2, n;
        int order [5] = '{0, 1, 2, 3, 0};
        req_valid = '0; req_a = '0; req_b = '0; rsp_ack = '0;
        ready_off = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // single request with latency check
        exp_q.push_back(4'b0001);
        set_req(0, 32'h3F80_0000, 32'h4000_0000);
        wait_ready(0, n1);
        req_valid[0] = 1'b0;
        check("single_ready_latency", n1, 1);
        check("single_dv_with_ready", cmp_data_valid, 1);
        tick();
        check("single_dv_one_cycle", cmp_data_valid, 0);
        check("single_ready_one_cycle", req_ready, 0);
        wait_rsp(0, n2);
        check("single_rsp_latency", n1 + 1 + n2, 5);
        check("single_read_done", cmp_read_done, 1);
        finish_rsp(0, 3'b001);

        // round-robin with everyone requesting continuously
        do_reset();
        for (int g = 0; g < 5; g++) exp_q.push_back(4'(1 << order[g]));
        for (int i = 0; i < N; i++) set_req(i, rr_a[i], rr_b[i]);
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready === '0 && n < 60) begin tick(); n++; end
            if (req_ready === '0) check("timeout_rr_grant", 0, 1);
            if (g == 4) req_valid = '0;
            wait_rsp(order[g], n2);
            finish_rsp(order[g], rr_res[order[g]]);
        end

        // delayed ack (-0 vs +0) with requester 2 waiting (NaN vs 0)
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        set_req(0, 32'h8000_0000, 32'h0000_0000);
        wait_ready(0, n1);
        req_valid[0] = 1'b0;
        set_req(2, 32'h7FC0_0000, 32'h0000_0000);
        wait_rsp(0, n2);
        for (int c = 0; c < 10; c++) begin
            rsp_ack[1] = (c >= 4);
            tick();
            check("hold_rsp_valid", rsp_valid, 4'b0001);
            check("hold_rsp_result", rsp_result, 3'b010);
            check("hold_no_dv", cmp_data_valid, 0);
        end
        rsp_ack[1] = 1'b0;
        finish_rsp(0, 3'b010);
        wait_ready(2, n1);
        req_valid[2] = 1'b0;
        wait_rsp(2, n2);
        finish_rsp(2, 3'b000);

        // comparator not ready (-inf vs -100)
        ready_off = 1'b1;
        exp_q.push_back(4'b0010);
        set_req(1, 32'hFF80_0000, 32'hC2C8_0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("notready_no_grant", req_ready, 0);
            check("notready_no_dv", cmp_data_valid, 0);
        end
        ready_off = 1'b0;
        wait_ready(1, n1);
        req_valid[1] = 1'b0;
        wait_rsp(1, n2);
        finish_rsp(1, 3'b001);

        // reset during WAIT
        exp_q.push_back(4'b0010);
        set_req(1, 32'h3F80_0000, 32'h4000_0000);
        wait_ready(1, n1);
        req_valid[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // pointer back at 0: with 1 and 2 requesting, 1 wins
        exp_q.push_back(4'b0010);
        set_req(1, 32'h4000_0000, 32'h3F80_0000);
        set_req(2, 32'h3F80_0000, 32'h3F80_0000);
        wait_ready(1, n1);
        req_valid = '0;
        wait_rsp(1, n2);
        finish_rsp(1, 3'b100);
        exp_q.push_back(4'b1000);
        set_req(3, 32'h42C8_0000, 32'hC2C8_0000);
        wait_ready(3, n1);
        req_valid[3] = 1'b0;
        wait_rsp(3, n2);
        finish_rsp(3, 3'b100);

        repeat (3) tick();
        check("grants_all_seen", exp_q.size(), 0);
        check("final_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
